// File: rtl/gate_test_sequencer_pkg.sv
// Shared types and constants for the gate test sequencer.
package gate_test_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned VEC_W   = 2;
    localparam int unsigned ERR_W   = 3;

    // Reference response of the gate under test for vector {a,b}.
    function automatic logic gate_ref(input logic [VEC_W-1:0] v);
        return v[1] & v[0];
    endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Stimulus/response and handshake bundle between the sequencer and its environment.
interface gate_test_sequencer_if;
    import gate_test_sequencer_pkg::*;

    logic               start;
    logic               a;
    logic               b;
    logic               o_in;
    logic               busy;
    logic               done;
    logic               pass;
    logic [ERR_W-1:0]   err_cnt;
    logic [NUM_VEC-1:0] fail_vec;

    // Sequencer side
    modport master (
        input  start, o_in,
        output a, b, busy, done, pass, err_cnt, fail_vec
    );

    // Environment side (requester plus gate under test)
    modport slave (
        output start, o_in,
        input  a, b, busy, done, pass, err_cnt, fail_vec
    );

endinterface

// File: rtl/gate_test_sequencer_settle_timer.sv
// Counts enabled cycles; tc marks the last of SETTLE_CYCLES enabled cycles.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned SETTLE_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [SETTLE_W-1:0] r_cnt;
    logic                w_tc;

    assign w_tc = en && (r_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
    assign tc   = w_tc;

    // Settle counter: restarts on clear or terminal count
    always_ff @(posedge clk) begin
        if (rst || clr || w_tc) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + SETTLE_W'(1);
        end
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// Drives a 2-input gate through all input vectors, samples its output after a
// settle window and reports per-vector mismatches with a start/done handshake.
module gate_test_sequencer
    import gate_test_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned SETTLE_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    gate_test_sequencer_if.master        bus
);

    state_t             r_state, w_state_nxt;
    logic [VEC_W-1:0]   r_vec, w_vec_nxt;
    logic               r_a, w_a_nxt;
    logic               r_b, w_b_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_pass, w_pass_nxt;
    logic [ERR_W-1:0]   r_err, w_err_nxt;
    logic [NUM_VEC-1:0] r_fail, w_fail_nxt;
    logic               w_tc;
    logic               w_launch;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SETTLE_W      (SETTLE_W)
    ) u_settle_timer (
        .clk (clk),
        .rst (rst),
        .clr (r_state != ST_SETTLE),
        .en  (r_state == ST_SETTLE),
        .tc  (w_tc)
    );

    // Next-state and next-register values
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_busy_nxt  = r_busy;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;
        w_launch    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_launch = bus.start;
            end
            ST_SETTLE: begin
                if (w_tc) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (bus.o_in != gate_ref({r_a, r_b})) begin
                    w_fail_nxt[r_vec] = 1'b1;
                    w_err_nxt         = r_err + ERR_W'(1);
                end
                if (r_vec == VEC_W'(NUM_VEC - 1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_vec_nxt          = r_vec + VEC_W'(1);
                    {w_a_nxt, w_b_nxt} = r_vec + VEC_W'(1);
                    w_state_nxt        = ST_SETTLE;
                end
            end
            ST_DONE: begin
                w_pass_nxt  = (r_err == '0);
                w_busy_nxt  = 1'b0;
                w_a_nxt     = 1'b0;
                w_b_nxt     = 1'b0;
                w_state_nxt = ST_IDLE;
                // A start held through DONE launches the next run on the exit
                // edge, giving back-to-back runs 17 cycles apart.
                w_launch    = bus.start;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_launch) begin
            w_state_nxt = ST_SETTLE;
            w_vec_nxt   = '0;
            w_a_nxt     = 1'b0;
            w_b_nxt     = 1'b0;
            w_err_nxt   = '0;
            w_fail_nxt  = '0;
            w_pass_nxt  = 1'b0;
            w_busy_nxt  = 1'b1;
        end
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_busy  <= w_busy_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    assign bus.a        = r_a;
    assign bus.b        = r_b;
    assign bus.busy     = r_busy;
    assign bus.done     = (r_state == ST_DONE);
    assign bus.pass     = r_pass;
    assign bus.err_cnt  = r_err;
    assign bus.fail_vec = r_fail;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench for gate_test_sequencer: one instance with a selectable gate
// model (settle 3) and one with a 3-clock-delay gate (settle 1).
module tb_gate_test_sequencer;
    import gate_test_sequencer_pkg::*;

    typedef struct {
        int         start_edge;
        int         lat;
        logic [2:0] err;
        logic [3:0] fv;
        logic       pass_after;
        logic       busy_after;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   mode = 0;
    int   done_cnt1 = 0;
    int   done_cnt2 = 0;
    int   last_done1 = 0;
    bit   pend1 = 0;
    bit   pend2 = 0;
    exp_t cur1, cur2;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    gate_test_sequencer_if if1 ();
    gate_test_sequencer_if if2 ();

    gate_test_sequencer #(.SETTLE_CYCLES(3), .SETTLE_W(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(1), .SETTLE_W(4)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    // Gate models for instance 1
    logic good_q;
    assign #4 good_q = if1.a & if1.b;
    always_comb begin
        case (mode)
            1:       if1.o_in = 1'b1;
            2:       if1.o_in = ~(if1.a & if1.b);
            default: if1.o_in = good_q;
        endcase
    end

    // Slow gate for instance 2: AND output delayed by 3 clocks
    logic [2:0] dly = '0;
    always @(posedge clk) dly <= {dly[1:0], if2.a & if2.b};
    assign if2.o_in = dly[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected run result for a gate model: 0 AND, 1 stuck-at-1, 2 NAND,
    // 3 too slow (sample still shows earlier vectors' AND, which is 0).
    function automatic exp_t model(input int m, input int lat, input int se,
                                   input logic pa, input logic ba);
        exp_t e;
        logic r, o;
        e.start_edge = se;
        e.lat = lat;
        e.err = '0;
        e.fv = '0;
        for (int v = 0; v < 4; v++) begin
            r = (v == 3);
            case (m)
                1:       o = 1'b1;
                2:       o = ~r;
                3:       o = 1'b0;
                default: o = r;
            endcase
            if (o !== r) begin
                e.fv[v] = 1'b1;
                e.err = e.err + 3'd1;
            end
        end
        e.pass_after = pa & (e.err == 0);
        e.busy_after = ba;
        return e;
    endfunction

    // Scoreboard: pop on done, then check pass/busy one cycle later
    always @(negedge clk) begin
        if (pend1) begin
            check_eq("pass1", 32'(if1.pass), 32'(cur1.pass_after));
            check_eq("busy1", 32'(if1.busy), 32'(cur1.busy_after));
            pend1 = 0;
        end
        if (pend2) begin
            check_eq("pass2", 32'(if2.pass), 32'(cur2.pass_after));
            pend2 = 0;
        end
        if (if1.done) begin
            done_cnt1++;
            last_done1 = edge_n;
            check_eq("done1_expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                cur1 = q1.pop_front();
                check_eq("lat1", edge_n - cur1.start_edge, cur1.lat);
                check_eq("err1", 32'(if1.err_cnt), 32'(cur1.err));
                check_eq("fv1", 32'(if1.fail_vec), 32'(cur1.fv));
                pend1 = 1;
            end
        end
        if (if2.done) begin
            done_cnt2++;
            check_eq("done2_expected", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                cur2 = q2.pop_front();
                check_eq("lat2", edge_n - cur2.start_edge, cur2.lat);
                check_eq("err2", 32'(if2.err_cnt), 32'(cur2.err));
                check_eq("fv2", 32'(if2.fail_vec), 32'(cur2.fv));
                pend2 = 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int inst, input int target, input int budget);
        int k = 0;
        while (((inst == 1) ? done_cnt1 : done_cnt2) < target && k < budget) begin
            tick(1);
            k++;
        end
        check_eq((inst == 1) ? "timeout_done1" : "timeout_done2",
                 32'(((inst == 1) ? done_cnt1 : done_cnt2) >= target), 1);
    endtask

    task automatic pulse1(input int m);
        q1.push_back(model(m, 16, edge_n + 1, 1'b1, 1'b0));
        if1.start = 1'b1;
        tick(1);
        if1.start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_ab"}, 32'({if1.a, if1.b}), 0);
        check_eq({tag, "_busy"}, 32'(if1.busy), 0);
        check_eq({tag, "_done"}, 32'(if1.done), 0);
        check_eq({tag, "_pass"}, 32'(if1.pass), 0);
        check_eq({tag, "_err"}, 32'(if1.err_cnt), 0);
        check_eq({tag, "_fv"}, 32'(if1.fail_vec), 0);
    endtask

    initial begin
        int base, d1;
        if1.start = 1'b0;
        if2.start = 1'b0;
        tick(5);
        check_reset("rst");
        check_eq("rst_dut2", 32'({if2.busy, if2.err_cnt, if2.fail_vec}), 0);
        rst = 1'b0;
        tick(1);

        // Good, stuck-at-1 and NAND gates
        for (int m = 0; m < 3; m++) begin
            mode = m;
            pulse1(m);
            check_eq("busy_after_start", 32'(if1.busy), 1);
            wait_done(1, done_cnt1 + 1, 40);
            tick(2);
        end

        // Slow gate against a 1-cycle settle window
        q2.push_back(model(3, 8, edge_n + 1, 1'b1, 1'b0));
        if2.start = 1'b1;
        tick(1);
        if2.start = 1'b0;
        wait_done(2, 1, 30);
        tick(2);

        // Start pulses while busy are ignored
        mode = 0;
        base = done_cnt1;
        pulse1(0);
        for (int i = 0; i < 15; i++) begin
            if1.start = (i % 4 == 1);
            tick(1);
        end
        if1.start = 1'b0;
        wait_done(1, base + 1, 20);
        tick(20);
        check_eq("single_done", done_cnt1 - base, 1);

        // Start held high: back-to-back runs
        base = done_cnt1;
        q1.push_back(model(0, 16, edge_n + 1, 1'b0, 1'b1));
        q1.push_back(model(0, 16, edge_n + 18, 1'b1, 1'b0));
        if1.start = 1'b1;
        wait_done(1, base + 1, 40);
        d1 = last_done1;
        tick(1);
        if1.start = 1'b0;
        wait_done(1, base + 2, 40);
        check_eq("b2b_gap", last_done1 - d1, 17);
        tick(2);

        // Reset during settle of vector 2 aborts the run
        mode = 1;
        pulse1(1);
        tick(8);
        check_eq("vec2_ab", 32'({if1.a, if1.b}), 2);
        check_eq("vec2_err", 32'(if1.err_cnt), 2);
        rst = 1'b1;
        tick(1);
        check_reset("midrst");
        q1.delete();
        rst = 1'b0;
        base = done_cnt1;
        tick(30);
        check_eq("no_done_after_rst", done_cnt1 - base, 0);
        mode = 0;
        pulse1(0);
        wait_done(1, base + 1, 40);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
